uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_edge_bit_counter.sv | 46 ++++
 rtl/uart_rx_fsm.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, width defaults and oversampling
// constants for the UART receive FSM slice (uart_rx_fsm and its counter).
// Optional parity support in the slice is selected with UART_RX_PARITY_EN.
package uart_rx_pkg;

    // Default number of data bits per frame.
    localparam int unsigned DATA_WIDTH_DEF = 8;

    // Legal oversampling ratios for PRESCALE.
    localparam logic [5:0] PRESCALE_X8  = 6'd8;
    localparam logic [5:0] PRESCALE_X16 = 6'd16;
    localparam logic [5:0] PRESCALE_X32 = 6'd32;

    // Receive FSM states; explicit 3-bit codes keep the legacy encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Width of a counter indexing n items; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// uart_rx_edge_bit_counter: oversample (edge) counter and data-bit counter
// for the UART receiver. The FSM owns enable/clear; this block reports the
// bit-end strobe and whether the current data bit is the last one.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BIT_W      = cnt_width(DATA_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             cnt_clr,
    input  logic             bit_inc,
    input  logic [5:0]       prescale,
    output logic [5:0]       edge_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             bit_end,
    output logic             last_bit
);

    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(DATA_WIDTH - 1);

    // Bit end is the final oversample of the current bit period.
    assign bit_end  = cnt_en && (edge_cnt == (prescale - 6'd1));
    assign last_bit = (bit_cnt == LAST_IDX);

    // Oversample index: runs 0..prescale-1 while enabled, wraps at bit end.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            edge_cnt <= '0;
        end else if (cnt_en) begin
            edge_cnt <= bit_end ? '0 : edge_cnt + 6'd1;
        end
    end

    // Data-bit index: advances at each bit end while the FSM is in DATA.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            bit_cnt <= '0;
        end else if (bit_inc && bit_end) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive control FSM. Detects the start edge, steps
// through start/data/(parity)/stop bits using an external majority-voted
// sample, assembles the word LSB first and pulses a status flag per frame.
// Define UART_RX_PARITY_EN to build the PARITY state and parity check;
// without it PAR_EN/PAR_TYP are ignored and par_err is tied low.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [5:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int unsigned BIT_W = cnt_width(DATA_WIDTH);

    rx_state_e        state_q;
    rx_state_e        state_d;
    logic [5:0]       prescale_q;
    logic [BIT_W-1:0] bit_cnt;
    logic             bit_end;
    logic             last_bit;
    logic             start_det;
    logic             stop_end;
    logic             par_fail;

    assign start_det   = (state_q == ST_IDLE) && !RX_IN;
    assign stop_end    = (state_q == ST_STOP) && bit_end;
    assign dat_samp_en = (state_q != ST_IDLE);

    uart_rx_edge_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIT_W      (BIT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .cnt_en   (state_q != ST_IDLE),
        .cnt_clr  (state_q == ST_IDLE),
        .bit_inc  (state_q == ST_DATA),
        .prescale (prescale_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end),
        .last_bit (last_bit)
    );

`ifdef UART_RX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
    logic par_fail_q;

    // Parity configuration is frozen at the start edge for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (start_det) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    // Parity-fail flag: cleared per frame, set when the parity bit disagrees.
    always_ff @(posedge clk) begin
        if (rst || start_det) begin
            par_fail_q <= 1'b0;
        end else if ((state_q == ST_PARITY) && bit_end) begin
            par_fail_q <= (sampled_bit != (^P_DATA ^ par_typ_q));
        end
    end

    assign par_fail = par_fail_q;

    // Parity error pulse, raised alongside the stop-bit decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= stop_end && par_fail_q;
        end
    end
`else
    logic unused_par_cfg;

    assign unused_par_cfg = PAR_EN ^ PAR_TYP;
    assign par_fail       = 1'b0;
    assign par_err        = 1'b0;
`endif

    // Oversampling ratio is frozen at the start edge for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q <= PRESCALE_X8;
        end else if (start_det) begin
            prescale_q <= PRESCALE;
        end
    end

    // Next-state decisions are taken only at bit ends (or the start edge).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!RX_IN) state_d = ST_START;
            end
            ST_START: begin
                if (bit_end) state_d = sampled_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && last_bit) begin
`ifdef UART_RX_PARITY_EN
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word assembly, LSB first; bits are only overwritten at data bit ends,
    // so the previous word stays visible until the next frame's first bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            P_DATA <= '0;
        end else if ((state_q == ST_DATA) && bit_end) begin
            P_DATA[bit_cnt] <= sampled_bit;
        end
    end

    // Frame status pulses, one cycle after the stop bit end.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= stop_end && sampled_bit && !par_fail;
            stp_err    <= stop_end && !sampled_bit;
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: scoreboard bench for uart_rx_fsm. A line driver serialises
// frames, a behavioural sampler feeds sampled_bit, the expected outcome of
// each frame is queued at issue time and a monitor pops it on every pulse.
`timescale 1ns/1ps
module tb_uart_rx_fsm;

    localparam int W = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         RX_IN;
    logic [5:0]   PRESCALE;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         sampled_bit;
    logic         dat_samp_en;
    logic [5:0]   edge_cnt;
    logic [W-1:0] P_DATA;
    logic         data_valid;
    logic         par_err;
    logic         stp_err;

    typedef struct packed {
        logic         dv;
        logic         pe;
        logic         se;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int unsigned  p_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] held = '0;
    int unsigned  cur_p = 8;
    logic         samp_q = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fsm #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .PRESCALE    (PRESCALE),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    // Data sampling stage stand-in: take the line at mid-bit of the frame.
    always @(posedge clk) begin
        if (dat_samp_en === 1'b1 && edge_cnt == 6'(cur_p / 2)) samp_q <= RX_IN;
    end
    assign sampled_bit = samp_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int unsigned n);
        RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    // Serialise one frame; abort_at >= 0 resets the DUT during that data bit.
    task automatic send_frame(input logic [W-1:0] data, input logic [5:0] p,
                              input bit pen, input bit ptyp, input bit par_bit,
                              input bit stop_bit, input int abort_at);
        bit   line[$];
        bit   pen_eff;
        bit   aborted;
        exp_t e;
        pen_eff = pen && PAR_BUILT;
        aborted = 1'b0;
        line.push_back(1'b0);
        for (int i = 0; i < W; i++) line.push_back(data[i]);
        if (pen_eff) line.push_back(par_bit);
        line.push_back(stop_bit);
        // Parity rule: ones in data+parity must be even (PAR_TYP=0) or odd.
        e.data = data;
        e.pe   = pen_eff && ((($countones(data) + int'(par_bit)) % 2) != int'(ptyp));
        e.se   = !stop_bit;
        e.dv   = stop_bit && !e.pe;
        if (abort_at < 0) exp_q.push_back(e);
        p_q.push_back(int'(p));
        cur_p = p;
        for (int b = 0; b < line.size(); b++) begin
            RX_IN = line[b];
            if (b == 0) begin
                PRESCALE = p;
                PAR_EN   = pen;
                PAR_TYP  = ptyp;
            end
            for (int c = 0; c < int'(p); c++) begin
                if (abort_at >= 0 && b == abort_at + 1 && c == int'(p) / 2) begin
                    rst   = 1'b1;
                    RX_IN = 1'b1;
                    tick();
                    rst = 1'b0;
                    @(negedge clk);
                    check("abort_data_valid", data_valid, 0);
                    check("abort_par_err", par_err, 0);
                    check("abort_stp_err", stp_err, 0);
                    check("abort_idle", dat_samp_en, 0);
                    check("abort_edge_cnt", edge_cnt, 0);
                    check("abort_p_data", P_DATA, 0);
                    held = '0;
                    tick();
                    aborted = 1'b1;
                    break;
                end
                if (b == 0 && c == 2) begin
                    // Mid-frame configuration churn must not disturb this frame.
                    PRESCALE = (p == 6'd8) ? 6'd32 : 6'd8;
                    PAR_EN   = !pen;
                    PAR_TYP  = !ptyp;
                end
                @(negedge clk);
                if (b == 0 && c == int'(p) / 2) check("p_data_held", P_DATA, held);
                @(posedge clk);
                #1;
            end
            if (aborted) break;
        end
        if (!aborted) held = data;
    endtask

    // Start bit that lasts only two cycles: must fall back to IDLE silently.
    task automatic glitch(input logic [5:0] p);
        p_q.push_back(int'(p));
        cur_p    = p;
        PRESCALE = p;
        RX_IN    = 1'b0;
        tick();
        tick();
        RX_IN = 1'b1;
        @(negedge clk);
        check("glitch_in_start", dat_samp_en, 1);
        @(posedge clk);
        #1;
        repeat (int'(p) + 4) tick();
        @(negedge clk);
        check("glitch_data_valid", data_valid, 0);
        check("glitch_par_err", par_err, 0);
        check("glitch_stp_err", stp_err, 0);
        check("glitch_idle", dat_samp_en, 0);
        check("glitch_p_data", P_DATA, held);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every status pulse consumes one expected outcome.
    initial begin : pulse_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {data_valid, par_err, stp_err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_valid", data_valid, e.dv);
                    check("par_err", par_err, e.pe);
                    check("stp_err", stp_err, e.se);
                    check("P_DATA", P_DATA, e.data);
                end
            end
        end
    end

    // Oversample index: counts 0..P-1 with wrap through each busy stretch.
    initial begin : edge_monitor
        int          run = -1;
        int unsigned run_p = 8;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                run = -1;
            end else if (dat_samp_en !== 1'b1) begin
                if (run >= 0 || edge_cnt !== '0) check("edge_cnt_idle", edge_cnt, 0);
                run = -1;
            end else begin
                if (run < 0) begin
                    run = 0;
                    if (p_q.size() == 0) begin
                        check("unexpected_frame_start", dat_samp_en, 0);
                        run_p = 8;
                    end else begin
                        run_p = p_q.pop_front();
                    end
                end
                check("edge_cnt", edge_cnt, 32'(run) % run_p);
                run++;
            end
        end
    end

    initial begin : stimulus
        bit prev_b2b;
        rst      = 1'b1;
        RX_IN    = 1'b1;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        prev_b2b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_data_valid", data_valid, 0);
        check("rst_par_err", par_err, 0);
        check("rst_stp_err", stp_err, 0);
        check("rst_dat_samp_en", dat_samp_en, 0);
        check("rst_edge_cnt", edge_cnt, 0);
        check("rst_p_data", P_DATA, 0);
        @(posedge clk);
        #1;

        // x8, no parity, good stop.
        send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle_cycles(4);
        // x16, even parity, wrong parity bit.
        send_frame(8'h0F, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle_cycles(4);
        // x8, stop bit low.
        send_frame(8'h3C, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle_cycles(3);
        @(negedge clk);
        check("stop_err_back_idle", dat_samp_en, 0);
        @(posedge clk);
        #1;
        // Short start pulse.
        glitch(6'd8);
        idle_cycles(3);
        // x32, two frames back to back.
        send_frame(8'h55, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hAA, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle_cycles(4);
        // Reset during data bit 3.
        send_frame(8'hC3, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        idle_cycles(4);

        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] d;
            logic [5:0]   p;
            int unsigned  gap;
            d = W'($urandom());
            case ($urandom_range(0, 2))
                0:       p = 6'd8;
                1:       p = 6'd16;
                default: p = 6'd32;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                idle_cycles(3);
                glitch(p);
                idle_cycles(2);
                prev_b2b = 1'b0;
            end
            send_frame(d, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), -1);
            gap = prev_b2b ? $urandom_range(2, 4) : $urandom_range(0, 3);
            prev_b2b = (gap == 0);
            idle_cycles(gap);
        end

        idle_cycles(50);
        check("scoreboard_drained", exp_q.size(), 0);
        check("frames_all_started", p_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
